fir_frame_scheduler: RTL and testbench
======================================

// Module: fir_frame_scheduler
// PURPOSE
//  Sequences the W4823 FIR core. Runs the coefficient-load phase into CMEM,
//  then buffers input samples in a small FIFO and launches one FIR frame per
//  sample. Captures each FP16 result into a valid/ready output register, and
//  stalls new frames while that result is unconsumed.
//  Sits between the sample/coefficient sources and the FIR core; single clock domain.
// PARAMETERS
//  NTAPS        64   coefficient words per load; cmem_addr width = clog2(NTAPS)
//  FIFO_DEPTH   4    input sample FIFO entries; power of two, >=2
//  FRAME_CYCLES 256  clk_fast cycles per FIR frame (core_start to frame end)
//  RESULT_LAT   250  frame cycle in which core_dout is valid; 1 <= RESULT_LAT < FRAME_CYCLES
// PORTS
//  clk_fast    in   1   fast clock, all logic on posedge
//  rst_n       in   1   reset, asynchronous, active-low
//  s_valid     in   1   input sample valid
//  s_ready     out  1   input sample ready (= FIFO not full)
//  s_data      in   16  FP16 input sample
//  c_valid     in   1   coefficient word valid
//  c_ready     out  1   coefficient ready (high only in CLOAD)
//  c_data      in   17  FP16i coefficient word
//  cfg_reload  in   1   request to re-enter coefficient load
//  cmem_wr     out  1   CMEM write strobe, one cycle per word
//  cmem_addr   out  6   CMEM write address
//  cmem_din    out  17  CMEM write data
//  core_start  out  1   one-cycle frame start pulse to the FIR core
//  core_din    out  16  sample for the current frame, held stable through RUN
//  core_dout   in   16  FIR core FP16 result
//  m_valid     out  1   result valid
//  m_ready     in   1   result accepted
//  m_data      out  16  captured FP16 result
//  busy        out  1   high in CLOAD or RUN
//  frame_cnt   out  16  frames launched, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (async):
//   - state=CLOAD; FIFO emptied; waddr=0; cnt=0; reload_pend=0.
//   - Every output is 0 except c_ready=1, busy=1 and s_ready=1 (FIFO empty).
//   - Reset mid-frame aborts the frame; coefficients must be reloaded.
//  FIFO:
//   - Push when s_valid&s_ready. Pop only in the IDLE launch decision.
//   - A word pushed in cycle t is poppable from t+1.
//   - Push and pop in the same cycle are both legal when the FIFO is non-empty.
//   - s_ready is independent of state; samples are accepted during CLOAD and RUN.
//  CLOAD:
//   - c_ready=1. On c_valid: next cycle cmem_wr=1, cmem_addr=waddr, cmem_din=c_data; then waddr++.
//   - Accepting the word with waddr==NTAPS-1 sets waddr=0 and moves to IDLE next cycle.
//   - Outside CLOAD: c_ready=0, c_valid is ignored, cmem_wr=0.
//  IDLE, priority order:
//   1. cfg_reload or reload_pend: go to CLOAD; clear reload_pend.
//   2. FIFO non-empty and m_valid==0: pop; core_din<=head; go to RUN with cnt=0;
//      frame_cnt++; core_start=1 in the first RUN cycle (frame cycle 0).
//   3. Otherwise stay in IDLE.
//  RUN:
//   - cnt counts frame cycles 0..FRAME_CYCLES-1.
//   - At cnt==RESULT_LAT: m_data<=core_dout, and m_valid=1 from the next cycle.
//   - At cnt==FRAME_CYCLES-1: go to IDLE next cycle.
//   - cfg_reload during RUN sets reload_pend; the frame always completes.
//  Output:
//   - m_valid clears in the cycle after m_valid&m_ready.
//   - m_data is held while m_valid=1 and is never overwritten: launches require m_valid==0.
//  Timing:
//   - Minimum frame period is FRAME_CYCLES+1 (one IDLE cycle between frames).
//   - Latency from s_valid&s_ready accept into an empty FIFO while IDLE to core_start is 2 cycles.
//   - Latency from core_start to m_valid is RESULT_LAT+1 cycles.
//  busy=1 in CLOAD or RUN.
// TESTING
//  1. Reset, then 64 c_data words 0x00000..0x0003F streamed back-to-back
//     -> cmem_wr for 64 cycles, addr 0..63, din==addr; then IDLE and c_ready=0.
//  2. After load, one sample 0x3C00 with m_ready=1
//     -> core_start 2 cycles after accept; core_din=0x3C00;
//        m_valid 251 cycles after core_start with m_data=core_dout; frame_cnt=1.
//  3. Push 5 samples with m_ready held 0 -> s_ready low after 4 accepted;
//     only 1 frame starts; second core_start only after m_ready pulse.
//  4. cfg_reload pulsed at frame cycle 100 -> frame completes, result captured;
//     then CLOAD with c_ready=1; queued samples held until 64 new words loaded.
//  5. Assert rst_n low at frame cycle 128 with 3 samples queued
//     -> outputs reset immediately, FIFO empty, state CLOAD, frame_cnt=0.
//  6. Continuous samples, m_ready=1 -> core_start period exactly 257 cycles;
//     frame_cnt wraps 0xFFFF->0 (force counter preload).

Source files
------------

// File: rtl/fir_frame_scheduler.sv
// Frame sequencer for the W4823 FIR core: loads coefficients into CMEM, queues
// input samples, launches one frame per sample and holds each result for a valid/ready consumer.
module fir_frame_scheduler #(
  parameter  int NTAPS        = 64,
  parameter  int FIFO_DEPTH   = 4,
  parameter  int FRAME_CYCLES = 256,
  parameter  int RESULT_LAT   = 250,
  localparam int AW           = $clog2(NTAPS),
  localparam int PW           = $clog2(FIFO_DEPTH),
  localparam int CW           = $clog2(FRAME_CYCLES)
) (
  input  logic          clk_fast,
  input  logic          rst_n,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  input  logic [15:0]   s_data_i,
  input  logic          c_valid_i,
  output logic          c_ready_o,
  input  logic [16:0]   c_data_i,
  input  logic          cfg_reload_i,
  output logic          cmem_wr_o,
  output logic [AW-1:0] cmem_addr_o,
  output logic [16:0]   cmem_din_o,
  output logic          core_start_o,
  output logic [15:0]   core_din_o,
  input  logic [15:0]   core_dout_i,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [15:0]   m_data_o,
  output logic          busy_o,
  output logic [15:0]   frame_cnt_o
);

  typedef enum logic [1:0] {
    ST_CLOAD = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t        state_q, state_d;

  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [PW:0]   wr_ptr_q, rd_ptr_q;
  logic          fifo_empty, fifo_full, push, pop;

  logic [AW-1:0] waddr_q, waddr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          reload_pend_q, reload_pend_d;
  logic          m_valid_q, m_valid_d;
  logic [15:0]   m_data_q;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [15:0]   core_din_q;
  logic          core_start_q;
  logic          cmem_wr_q;
  logic [AW-1:0] cmem_addr_q;
  logic [16:0]   cmem_din_q;

  logic          c_accept, reload_req, launch, capture, frame_last;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign push       = s_valid_i && !fifo_full;
  assign pop        = launch;

  assign c_accept   = (state_q == ST_CLOAD) && c_valid_i;
  assign reload_req = cfg_reload_i || reload_pend_q;
  assign launch     = (state_q == ST_IDLE) && !reload_req && !fifo_empty && !m_valid_q;
  assign capture    = (state_q == ST_RUN) && (cnt_q == CW'(RESULT_LAT));
  assign frame_last = (state_q == ST_RUN) && (cnt_q == CW'(FRAME_CYCLES - 1));

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLOAD: if (c_accept && (waddr_q == AW'(NTAPS - 1))) state_d = ST_IDLE;
      ST_IDLE: begin
        if (reload_req)  state_d = ST_CLOAD;
        else if (launch) state_d = ST_RUN;
      end
      ST_RUN:   if (frame_last) state_d = ST_IDLE;
      default:  state_d = ST_CLOAD;
    endcase
  end

  always_comb begin
    c_ready_o = 1'b0;
    busy_o    = 1'b0;
    case (state_q)
      ST_CLOAD: begin
        c_ready_o = 1'b1;
        busy_o    = 1'b1;
      end
      ST_RUN:   busy_o = 1'b1;
      default: begin
        c_ready_o = 1'b0;
        busy_o    = 1'b0;
      end
    endcase
  end

  always_comb begin
    waddr_d = waddr_q;
    if (c_accept) waddr_d = (waddr_q == AW'(NTAPS - 1)) ? '0 : waddr_q + AW'(1);

    cnt_d = cnt_q;
    if (launch)                 cnt_d = '0;
    else if (state_q == ST_RUN) cnt_d = cnt_q + CW'(1);

    // A reload seen mid-frame is remembered and honoured at the next IDLE.
    reload_pend_d = reload_pend_q;
    if (state_q == ST_IDLE)                    reload_pend_d = 1'b0;
    else if (state_q == ST_RUN && cfg_reload_i) reload_pend_d = 1'b1;

    m_valid_d = m_valid_q;
    if (capture)                      m_valid_d = 1'b1;
    else if (m_valid_q && m_ready_i)  m_valid_d = 1'b0;
  end

  assign frame_cnt_d = launch ? frame_cnt_q + 16'd1 : frame_cnt_q;

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      waddr_q       <= '0;
      cnt_q         <= '0;
      reload_pend_q <= 1'b0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      frame_cnt_q   <= '0;
      core_din_q    <= '0;
      core_start_q  <= 1'b0;
      cmem_wr_q     <= 1'b0;
      cmem_addr_q   <= '0;
      cmem_din_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
      waddr_q       <= waddr_d;
      cnt_q         <= cnt_d;
      reload_pend_q <= reload_pend_d;
      m_valid_q     <= m_valid_d;
      frame_cnt_q   <= frame_cnt_d;
      core_start_q  <= launch;
      cmem_wr_q     <= c_accept;
      if (capture) m_data_q <= core_dout_i;
      if (launch)  core_din_q <= fifo_mem[rd_ptr_q[PW-1:0]];
      if (c_accept) begin
        cmem_addr_q <= waddr_q;
        cmem_din_q  <= c_data_i;
      end
    end
  end

  always_ff @(posedge clk_fast) begin
    if (push) fifo_mem[wr_ptr_q[PW-1:0]] <= s_data_i;
  end

  assign s_ready_o    = !fifo_full;
  assign cmem_wr_o    = cmem_wr_q;
  assign cmem_addr_o  = cmem_addr_q;
  assign cmem_din_o   = cmem_din_q;
  assign core_start_o = core_start_q;
  assign core_din_o   = core_din_q;
  assign m_valid_o    = m_valid_q;
  assign m_data_o     = m_data_q;
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_fir_frame_scheduler.sv
// Self-checking bench for fir_frame_scheduler: every cycle is compared against a
// queue-based behavioural model, plus explicit latency/period checks per scenario.
module tb_fir_frame_scheduler;
  localparam int NTAPS        = 64;
  localparam int FIFO_DEPTH   = 4;
  localparam int FRAME_CYCLES = 256;
  localparam int RESULT_LAT   = 250;

  logic        clk_fast = 1'b0;
  logic        rst_n    = 1'b1;
  logic        s_valid  = 1'b0;
  logic [15:0] s_data   = '0;
  logic        c_valid  = 1'b0;
  logic [16:0] c_data   = '0;
  logic        cfg_reload = 1'b0;
  logic [15:0] core_dout  = '0;
  logic        m_ready  = 1'b0;
  logic        s_ready, c_ready, cmem_wr, core_start, m_valid, busy;
  logic [5:0]  cmem_addr;
  logic [16:0] cmem_din;
  logic [15:0] core_din, m_data, frame_cnt;

  always #5 clk_fast = ~clk_fast;

  fir_frame_scheduler #(
    .NTAPS(NTAPS), .FIFO_DEPTH(FIFO_DEPTH),
    .FRAME_CYCLES(FRAME_CYCLES), .RESULT_LAT(RESULT_LAT)
  ) dut (
    .clk_fast(clk_fast), .rst_n(rst_n),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .c_valid_i(c_valid), .c_ready_o(c_ready), .c_data_i(c_data),
    .cfg_reload_i(cfg_reload),
    .cmem_wr_o(cmem_wr), .cmem_addr_o(cmem_addr), .cmem_din_o(cmem_din),
    .core_start_o(core_start), .core_din_o(core_din), .core_dout_i(core_dout),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
    .busy_o(busy), .frame_cnt_o(frame_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  int stp   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, stp);
    end
  endtask

  // Behavioural model: loading/running flags, frame age, sample queue, result slot.
  bit          m_load, m_run, m_pend, m_mv, m_cwr, m_start;
  int          m_waddr, m_age;
  logic [15:0] m_q [$];
  logic [15:0] m_md, m_fc, m_core_din;
  logic [5:0]  m_caddr;
  logic [16:0] m_cdin;
  bit          fc_preload = 1'b0;
  bit          stream = 1'b0;

  logic [15:0] dout_hist [int];
  int          wr_cnt = 0;
  int          start_cnt = 0;
  int          mv_last = -1;
  bit          mv_prev = 1'b0;

  task automatic model_reset();
    m_load = 1'b1; m_run = 1'b0; m_pend = 1'b0; m_mv = 1'b0; m_cwr = 1'b0; m_start = 1'b0;
    m_waddr = 0; m_age = 0; m_q.delete();
    m_md = '0; m_fc = '0; m_core_din = '0; m_caddr = '0; m_cdin = '0;
  endtask

  task automatic check_outputs();
    chk("s_ready", s_ready, m_q.size() < FIFO_DEPTH);
    chk("c_ready", c_ready, m_load);
    chk("busy", busy, m_load || m_run);
    chk("cmem_wr", cmem_wr, m_cwr);
    if (m_cwr) begin
      chk("cmem_addr", cmem_addr, m_caddr);
      chk("cmem_din", cmem_din, m_cdin);
    end
    chk("core_start", core_start, m_start);
    chk("core_din", core_din, m_core_din);
    chk("m_valid", m_valid, m_mv);
    chk("m_data", m_data, m_md);
    chk("frame_cnt", frame_cnt, m_fc);
  endtask

  // Advance one clock: predict from the inputs of this cycle, clock, compare.
  task automatic step();
    bit          n_load = m_load, n_run = m_run, n_pend = m_pend, n_mv = m_mv;
    bit          n_cwr = 1'b0, n_start = 1'b0, do_pop = 1'b0, do_push;
    int          n_waddr = m_waddr, n_age = m_age;
    logic [15:0] n_md = m_md, n_fc = m_fc, n_core = m_core_din;
    logic [5:0]  n_caddr = m_caddr;
    logic [16:0] n_cdin = m_cdin;
    logic [15:0] sd = s_data;
    do_push = s_valid && (m_q.size() < FIFO_DEPTH);
    if (m_load) begin
      if (c_valid) begin
        n_cwr = 1'b1; n_caddr = m_waddr[5:0]; n_cdin = c_data;
        if (m_waddr == NTAPS - 1) begin n_load = 1'b0; n_waddr = 0; end
        else n_waddr = m_waddr + 1;
      end
    end else if (m_run) begin
      if (cfg_reload) n_pend = 1'b1;
      if (m_age == RESULT_LAT) begin n_mv = 1'b1; n_md = core_dout; end
      if (m_age == FRAME_CYCLES - 1) n_run = 1'b0;
      else n_age = m_age + 1;
    end else begin
      if (cfg_reload || m_pend) begin
        n_load = 1'b1; n_pend = 1'b0;
      end else if (m_q.size() != 0 && !m_mv) begin
        do_pop = 1'b1; n_core = m_q[0]; n_run = 1'b1; n_age = 0;
        n_fc = m_fc + 16'd1; n_start = 1'b1;
      end
    end
    if (m_mv && m_ready) n_mv = 1'b0;
    if (fc_preload) n_fc = 16'hFFFF;

    @(posedge clk_fast);
    #1;
    stp++;
    if (do_pop) void'(m_q.pop_front());
    if (do_push) m_q.push_back(sd);
    m_load = n_load; m_run = n_run; m_pend = n_pend; m_mv = n_mv; m_cwr = n_cwr;
    m_start = n_start; m_waddr = n_waddr; m_age = n_age; m_md = n_md; m_fc = n_fc;
    m_core_din = n_core; m_caddr = n_caddr; m_cdin = n_cdin;
    core_dout = 16'($urandom);
    dout_hist[stp] = core_dout;
    if (stream) s_data = 16'($urandom);
    if (cmem_wr) wr_cnt++;
    if (core_start) start_cnt++;
    if (m_valid && !mv_prev) mv_last = stp;
    mv_prev = m_valid;
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  function automatic logic sel_sig(input int which);
    case (which)
      0:       return core_start;
      1:       return m_valid;
      default: return c_ready;
    endcase
  endfunction

  task automatic wait_until(input int which, input int budget, input string tag);
    int k = 0;
    do begin
      step();
      k++;
    end while (sel_sig(which) !== 1'b1 && k < budget);
    chk(tag, sel_sig(which), 1'b1);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk({tag, "_c_ready"}, c_ready, 1'b1);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_s_ready"}, s_ready, 1'b1);
    chk({tag, "_cmem_wr"}, cmem_wr, 1'b0);
    chk({tag, "_cmem_addr"}, cmem_addr, 6'd0);
    chk({tag, "_cmem_din"}, cmem_din, 17'd0);
    chk({tag, "_core_start"}, core_start, 1'b0);
    chk({tag, "_core_din"}, core_din, 16'd0);
    chk({tag, "_m_valid"}, m_valid, 1'b0);
    chk({tag, "_m_data"}, m_data, 16'd0);
    chk({tag, "_frame_cnt"}, frame_cnt, 16'd0);
    @(posedge clk_fast);
    @(posedge clk_fast);
    #1;
    stp += 2;
    mv_prev = m_valid;
    check_outputs();
    rst_n = 1'b1;
  endtask

  task automatic load_coefs(input bit incr);
    int i = 0;
    int guard = 0;
    while (i < NTAPS && guard < 1000) begin
      c_valid = incr ? 1'b1 : ($urandom_range(3) != 0);
      c_data  = incr ? 17'(i) : 17'($urandom);
      if (c_valid && c_ready) i++;
      step();
      guard++;
    end
    c_valid = 1'b0;
    chk("load_words", i, NTAPS);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, st, p, acc_cnt, t0, starts0;
    model_reset();

    // 1: reset, then sequential coefficient load
    do_reset("rst1");
    wr_cnt = 0;
    load_coefs(1'b1);
    chk("t1_writes", wr_cnt, NTAPS);
    chk("t1_c_ready_idle", c_ready, 1'b0);
    chk("t1_busy_idle", busy, 1'b0);

    // 2: single sample, full launch/result latency
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 16'h3C00;
    acc = stp;
    step();
    s_valid = 1'b0;
    wait_until(0, 10, "t2_start_seen");
    st = stp;
    chk("t2_start_lat", stp - acc, 2);
    chk("t2_core_din", core_din, 16'h3C00);
    chk("t2_frame_cnt", frame_cnt, 16'd1);
    wait_until(1, 300, "t2_mvalid_seen");
    chk("t2_mvalid_lat", stp - st, RESULT_LAT + 1);
    chk("t2_m_data", m_data, dout_hist[st + RESULT_LAT]);
    run(8);

    // 3: backpressure -- results unconsumed, FIFO fills, launches stall
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 16'($urandom);
    step();
    s_valid = 1'b0;
    wait_until(0, 10, "t3_first_start");
    run(3);
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 16'($urandom);
      if (s_ready) acc_cnt++;
      step();
    end
    s_valid = 1'b0;
    chk("t3_accepted", acc_cnt, FIFO_DEPTH);
    chk("t3_full", s_ready, 1'b0);
    wait_until(1, 300, "t3_result");
    starts0 = start_cnt;
    run(300);
    chk("t3_no_new_start", start_cnt - starts0, 0);
    chk("t3_frame_cnt", frame_cnt, 16'd2);
    m_ready = 1'b1;
    p = stp;
    step();
    m_ready = 1'b0;
    wait_until(0, 10, "t3_restart");
    chk("t3_restart_lat", stp - p, 2);
    chk("t3_frame_cnt2", frame_cnt, 16'd3);

    // 4: reload requested at frame cycle 100
    st = stp;
    m_ready = 1'b1;
    run(100);
    cfg_reload = 1'b1;
    step();
    cfg_reload = 1'b0;
    wait_until(2, 400, "t4_cload");
    chk("t4_cload_cycle", stp - st, FRAME_CYCLES + 1);
    chk("t4_result_cycle", mv_last - st, RESULT_LAT + 1);
    chk("t4_frame_cnt", frame_cnt, 16'd3);
    load_coefs(1'b0);
    chk("t4_held", frame_cnt, 16'd3);
    wait_until(0, 5, "t4_resume");
    chk("t4_frame_cnt2", frame_cnt, 16'd4);

    // 5: reset at frame cycle 128 with 3 samples queued
    st = stp;
    s_valid = 1'b1; s_data = 16'($urandom);
    step();
    s_valid = 1'b0;
    run(127);
    chk("t5_queued", m_q.size(), 3);
    do_reset("rst5");
    run(4);
    load_coefs(1'b0);

    // 6: streaming samples, period and frame counter wrap
    force dut.frame_cnt_d = 16'hFFFF;
    fc_preload = 1'b1;
    step();
    release dut.frame_cnt_d;
    fc_preload = 1'b0;
    chk("t6_preload", frame_cnt, 16'hFFFF);
    stream = 1'b1;
    s_valid = 1'b1; s_data = 16'($urandom);
    wait_until(0, 10, "t6_start0");
    chk("t6_wrap", frame_cnt, 16'd0);
    t0 = stp;
    wait_until(0, 300, "t6_start1");
    chk("t6_period1", stp - t0, FRAME_CYCLES + 1);
    t0 = stp;
    wait_until(0, 300, "t6_start2");
    chk("t6_period2", stp - t0, FRAME_CYCLES + 1);
    chk("t6_frame_cnt", frame_cnt, 16'd2);
    stream = 1'b0;
    s_valid = 1'b0;
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
